// File: rtl/prio_scan_display.sv
// prio_scan_display: priority-encodes a request vector and shows the winning index in decimal on a scanned active-low 7-segment bank.
module prio_scan_display #(
  parameter int N_IN = 16,
  parameter int DIGITS = 2,
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1,
  localparam int IDXW = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   x,
  input  logic              en,
  input  logic              hold,
  output logic [IDXW-1:0]   code,
  output logic              valid,
  output logic [6:0]        h,
  output logic [DIGITS-1:0] an
);
  localparam int BW = 12;
  localparam int CW = $clog2(IDXW + 1);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_d;
  logic [N_IN-1:0] x_q;
  logic en_q;
  logic [IDXW:0] op, op_q, last_op;
  logic [IDXW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcd, disp_bcd;
  logic disp_valid, disp_ovf, run, wrap, lead;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic [6:0] seg;
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'b1000000;
      4'd1: dec7 = 7'b1111001;
      4'd2: dec7 = 7'b0100100;
      4'd3: dec7 = 7'b0110000;
      4'd4: dec7 = 7'b0011001;
      4'd5: dec7 = 7'b0010010;
      4'd6: dec7 = 7'b0000010;
      4'd7: dec7 = 7'b1111000;
      4'd8: dec7 = 7'b0000000;
      4'd9: dec7 = 7'b0010000;
      default: dec7 = 7'h7F;
    endcase
  endfunction
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b, input logic s);
    logic [BW-1:0] t;
    t = b;
    for (int i = 0; i < BW / 4; i++)
      if (t[4*i+:4] >= 4'd5) t[4*i+:4] = t[4*i+:4] + 4'd3;
    return {t[BW-2:0], s};
  endfunction
  always_comb begin
    code = '0;
    for (int i = 0; i < N_IN; i++) if (x_q[i]) code = IDXW'(i);
    if (!en_q) code = '0;
    valid = en_q && |x_q;
  end
  assign op = {valid, code};
  always_comb begin
    state_d = (state == IDLE) ? ((op != last_op) ? SHIFT : IDLE) :
              (state == SHIFT) ? ((cnt == CW'(IDXW - 1)) ? COMMIT : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // operand is latched at start so input changes mid-conversion only take effect on the next pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      en_q <= 1'b0;
      op_q <= '0;
      last_op <= '0;
      sh <= '0;
      cnt <= '0;
      bcd <= '0;
      disp_bcd <= '0;
      disp_valid <= 1'b0;
      disp_ovf <= 1'b0;
    end else begin
      if (!hold) begin
        x_q <= x;
        en_q <= en;
      end
      if (state == IDLE && op != last_op) begin
        op_q <= op;
        sh <= code;
        cnt <= '0;
        bcd <= '0;
      end
      if (state == SHIFT) begin
        bcd <= dabble(bcd, sh[IDXW-1]);
        sh <= sh << 1;
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        disp_bcd <= bcd;
        disp_valid <= op_q[IDXW];
        disp_ovf <= 32'(op_q[IDXW-1:0]) >= LIMIT;
        last_op <= op_q;
      end
    end
  end
  assign wrap = div == DW'(SCAN_DIV - 1);
  assign nib = 4'(disp_bcd >> (4 * idx));
  assign lead = LZ_BLANK != 0 && idx != '0 && (disp_bcd >> (4 * idx)) == '0;
  assign seg = !disp_valid ? 7'h7F : disp_ovf ? 7'b0111111 : lead ? 7'h7F : dec7(nib);
  // run delays the scanner one cycle so the first select lands on the 2nd edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      div <= '0;
      idx <= '0;
      h <= 7'h7F;
      an <= '1;
    end else begin
      run <= 1'b1;
      if (run) begin
        div <= wrap ? '0 : div + 1'b1;
        if (wrap) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        h <= seg;
        an <= ~(DIGITS'(1) << idx);
      end
    end
  end
endmodule

// File: tb/tb_prio_scan_display.sv
// tb_prio_scan_display: scoreboard bench for prio_scan_display; three instances cover the default, no-blanking/fast-scan and wide-vector builds.
module tb_prio_scan_display;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000, BL = 7'h7F, DASH = 7'b0111111;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, hold = 1'b0;
  logic [15:0] x = '0;
  logic [127:0] xw = '0;
  logic [3:0] code_a, code_b;
  logic [6:0] code_w;
  logic valid_a, valid_b, valid_w;
  logic [6:0] h_a, h_b, h_w;
  logic [1:0] an_a, an_b, an_w;
  typedef struct {
    int sel;
    int id;
    logic [7:0] code;
    logic v;
    logic [6:0] d0;
    logic [6:0] d1;
  } exp_t;
  exp_t q[$];
  int nvec = 0, nerr = 0;
  bit busy = 1'b0;
  always #5 clk = ~clk;
  prio_scan_display #(.N_IN(16), .DIGITS(2), .SCAN_DIV(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .hold(hold),
    .code(code_a), .valid(valid_a), .h(h_a), .an(an_a));
  prio_scan_display #(.N_IN(16), .DIGITS(2), .SCAN_DIV(1), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .hold(hold),
    .code(code_b), .valid(valid_b), .h(h_b), .an(an_b));
  prio_scan_display #(.N_IN(128), .DIGITS(2), .SCAN_DIV(4), .LZ_BLANK(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .x(xw), .en(en), .hold(hold),
    .code(code_w), .valid(valid_w), .h(h_w), .an(an_w));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic expect_v(input int sel, input int id, input logic [7:0] c, input logic v,
                          input logic [6:0] d0, input logic [6:0] d1);
    exp_t e;
    e.sel = sel;
    e.id = id;
    e.code = c;
    e.v = v;
    e.d0 = d0;
    e.d1 = d1;
    q.push_back(e);
  endtask
  task automatic settle();
    repeat (12) @(negedge clk);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (q.size() > 0 || busy); i++) @(negedge clk);
    chk("drain", 32'(q.size() > 0 || busy), 32'd0);
  endtask
  // monitor: pops an expectation and watches both digit slots over a full scan period
  initial begin
    exp_t e;
    logic [1:0] am;
    logic [6:0] hm, g0, g1;
    logic [7:0] cm;
    logic vm;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        busy = 1'b1;
        g0 = 'x;
        g1 = 'x;
        cm = 'x;
        vm = 'x;
        for (int i = 0; i < 16; i++) begin
          am = e.sel == 0 ? an_a : e.sel == 1 ? an_b : an_w;
          hm = e.sel == 0 ? h_a : e.sel == 1 ? h_b : h_w;
          cm = e.sel == 0 ? 8'(code_a) : e.sel == 1 ? 8'(code_b) : 8'(code_w);
          vm = e.sel == 0 ? valid_a : e.sel == 1 ? valid_b : valid_w;
          if (am == 2'b10) g0 = hm;
          if (am == 2'b01) g1 = hm;
          if (i < 15) @(negedge clk);
        end
        chk($sformatf("v%0d.%0d code", e.id, e.sel), 32'(cm), 32'(e.code));
        chk($sformatf("v%0d.%0d valid", e.id, e.sel), 32'(vm), 32'(e.v));
        chk($sformatf("v%0d.%0d digit0", e.id, e.sel), 32'(g0), 32'(e.d0));
        chk($sformatf("v%0d.%0d digit1", e.id, e.sel), 32'(g1), 32'(e.d1));
        busy = 1'b0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int bad;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    x = 16'h8421;
    en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst h", 32'(h_a), 32'(BL));
    chk("rst an", 32'(an_a), 32'(2'b11));
    chk("rst code", 32'(code_a), 32'd0);
    chk("rst valid", 32'(valid_a), 32'd0);
    chk("rst h_b", 32'(h_b), 32'(BL));
    x = '0;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      chk($sformatf("scan an e%0d", e), 32'(an_a),
          32'(e == 1 ? 2'b11 : (((e - 2) / 4) % 2 == 1 ? 2'b01 : 2'b10)));
      chk($sformatf("scan blank e%0d", e), 32'(h_a), 32'(BL));
    end
    x = 16'h8421;
    en = 1'b1;
    chk("v1 code pre", 32'(code_a), 32'd0);
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (e == 1) begin
        chk("v1 code lat", 32'(code_a), 32'd15);
        chk("v1 valid lat", 32'(valid_a), 32'd1);
      end
      if (e == 7) chk("v1 b before refresh", 32'(h_b), 32'(BL));
      if (e >= 8) chk($sformatf("v1 b refresh e%0d", e), 32'(h_b), 32'(an_b == 2'b10 ? S5 : S1));
    end
    settle();
    expect_v(0, 1, 8'd15, 1'b1, S5, S1);
    expect_v(1, 1, 8'd15, 1'b1, S5, S1);
    expect_v(2, 1, 8'd0, 1'b0, BL, BL);
    drain();
    x = 16'h0004;
    settle();
    expect_v(0, 2, 8'd2, 1'b1, S2, BL);
    expect_v(1, 2, 8'd2, 1'b1, S2, S0);
    drain();
    x = 16'h0006;
    bad = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (h_b !== (an_b == 2'b10 ? S2 : S0)) bad++;
    end
    chk("same operand no glitch", 32'(bad), 32'd0);
    x = 16'h0000;
    settle();
    expect_v(0, 3, 8'd0, 1'b0, BL, BL);
    expect_v(1, 3, 8'd0, 1'b0, BL, BL);
    drain();
    x = 16'h8421;
    en = 1'b0;
    settle();
    expect_v(0, 4, 8'd0, 1'b0, BL, BL);
    expect_v(1, 4, 8'd0, 1'b0, BL, BL);
    drain();
    x = 16'h0004;
    en = 1'b1;
    settle();
    hold = 1'b1;
    x = 16'h0200;
    repeat (30) @(negedge clk);
    expect_v(0, 5, 8'd2, 1'b1, S2, BL);
    expect_v(1, 5, 8'd2, 1'b1, S2, S0);
    drain();
    hold = 1'b0;
    @(negedge clk);
    chk("hold release code", 32'(code_a), 32'd9);
    settle();
    expect_v(0, 6, 8'd9, 1'b1, S9, BL);
    expect_v(1, 6, 8'd9, 1'b1, S9, S0);
    drain();
    x = 16'h0001;
    bad = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 3) x = 16'h0800;
      if (!(an_b == 2'b10 ? (h_b == S9 || h_b == S0 || h_b == S1) :
            an_b == 2'b01 ? (h_b == S0 || h_b == S1) : 1'b0)) bad++;
      if (e == 8) chk("mid zero shown", 32'(h_b), 32'(S0));
      if (e == 13) chk("mid zero held", 32'(h_b), 32'(S0));
      if (e == 14) chk("mid eleven shown", 32'(h_b), 32'(S1));
    end
    chk("mid no corruption", 32'(bad), 32'd0);
    settle();
    expect_v(0, 7, 8'd11, 1'b1, S1, S1);
    expect_v(1, 7, 8'd11, 1'b1, S1, S1);
    drain();
    xw = 128'd1 << 100;
    settle();
    expect_v(2, 8, 8'd100, 1'b1, DASH, DASH);
    drain();
    xw = (128'd1 << 99) | (128'd1 << 3);
    settle();
    expect_v(2, 9, 8'd99, 1'b1, S9, S9);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
